// File: rtl/mem_stage_lsu.sv
// RV32I load/store unit for the MEM stage: one outstanding access, simple
// req/ack memory bus with a wait timeout, aligned lane steering and load extension.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic [1:0]        resp_err_code,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byte_en,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FUNCT3   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state;
  state_t             state_d;
  logic               accept;
  logic               illegal;
  logic               misaligned;
  logic [1:0]         req_code;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic               cnt_hit;
  logic [CNT_W-1:0]   wait_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic [4:0]         r_rd;
  logic [1:0]         r_code;
  logic [31:0]        rdata_q;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [31:0]        load_c;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE) | accept;
  assign cnt_hit   = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Request decode: illegal funct3 outranks misalignment
  always_comb begin
    illegal    = req_we ? (req_funct3 > 3'b010)
                        : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    req_code   = illegal ? ERR_FUNCT3 : (misaligned ? ERR_MISALIGN : ERR_NONE);
    be_c       = 4'b1111;
    wdata_c    = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << req_addr[1:0];
          wdata_c = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << req_addr[1:0];
          wdata_c = {2{req_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = req_wdata;
        end
      endcase
    end
  end

  // Load lane select and extension from the captured read word
  always_comb begin
    byte_lane = 8'(rdata_q >> {r_off, 3'b000});
    half_lane = 16'(rdata_q >> {r_off[1], 4'b0000});
    case (r_funct3)
      3'b000:  load_c = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_c = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_c = rdata_q;
      3'b100:  load_c = {24'd0, byte_lane};
      3'b101:  load_c = {16'd0, half_lane};
      default: load_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // RESP spans two cycles: load the response registers, then present them
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = (req_code != ERR_NONE) ? RESP : BUS;
      BUS:     if (bus_ack || cnt_hit) state_d = RESP;
      RESP:    if (resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      r_we          <= 1'b0;
      r_funct3      <= '0;
      r_off         <= '0;
      r_rd          <= '0;
      r_code        <= ERR_NONE;
      rdata_q       <= '0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_byte_en   <= '0;
      bus_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_rd       <= '0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_rd     <= req_rd;
            r_code   <= req_code;
            rdata_q  <= '0;
            wait_cnt <= '0;
            if (req_code == ERR_NONE) begin
              bus_req     <= 1'b1;
              bus_we      <= req_we;
              bus_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_byte_en <= be_c;
              bus_wdata   <= wdata_c;
            end
          end
        end
        BUS: begin
          if (bus_ack)      rdata_q  <= bus_rdata;
          else if (cnt_hit) r_code   <= ERR_TIMEOUT;
          else              wait_cnt <= wait_cnt + CNT_W'(1);
          if (bus_ack || cnt_hit) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_byte_en <= '0;
            bus_wdata   <= '0;
          end
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid    <= 1'b1;
            resp_err      <= (r_code != ERR_NONE);
            resp_err_code <= r_code;
            resp_data     <= (r_code == ERR_NONE && !r_we) ? load_c : 32'd0;
            resp_rd       <= (r_code == ERR_NONE && !r_we) ? r_rd : 5'd0;
          end else begin
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_err_code <= ERR_NONE;
            resp_data     <= '0;
            resp_rd       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed requests push expected bus and
// response records; independent monitors pop and compare.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byte_en;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    logic [1:0]  code;
  } resp_exp_t;

  bus_exp_t  exp_bus[$];
  resp_exp_t exp_resp[$];
  int n_chk = 0;
  int n_fail = 0;
  int ack_lat = 0;
  logic stray_ack = 1'b0;
  int last_burst = 0;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .busy(busy),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err), .resp_err_code(resp_err_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after ack_lat wait cycles; optional ack outside a request
  initial begin
    int cyc = 0;
    bus_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        bus_ack = (cyc == ack_lat);
        cyc++;
      end else begin
        cyc = 0;
        bus_ack = stray_ack;
      end
    end
  end

  // Bus monitor: first cycle of each request against the queue, then hold checks
  initial begin
    bus_exp_t ref_b;
    logic prev = 1'b0;
    int burst = 0;
    ref_b = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!prev) begin
          burst = 1;
          if (exp_bus.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL bus_unexpected: got addr 0x%08h expected no bus request", bus_addr);
            ref_b = '{bus_we, bus_addr, bus_byte_en, bus_wdata};
          end else begin
            ref_b = exp_bus.pop_front();
            chk("bus_we", 32'(bus_we), 32'(ref_b.we));
            chk("bus_addr", bus_addr, ref_b.addr);
            chk("bus_byte_en", 32'(bus_byte_en), 32'(ref_b.be));
            chk("bus_wdata", bus_wdata, ref_b.wdata);
          end
        end else begin
          burst++;
          chk("bus_hold_addr", bus_addr, ref_b.addr);
          chk("bus_hold_be", 32'(bus_byte_en), 32'(ref_b.be));
          chk("bus_hold_wdata", bus_wdata, ref_b.wdata);
          chk("bus_hold_we", 32'(bus_we), 32'(ref_b.we));
        end
      end else if (prev) begin
        last_burst = burst;
      end
      prev = bus_req;
    end
  end

  // Response monitor
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_unexpected: got data 0x%08h code %0d expected no response",
                   resp_data, resp_err_code);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_rd", 32'(resp_rd), 32'(e.rd));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_err_code", 32'(resp_err_code), 32'(e.code));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_ready_timeout", 32'(req_ready), 32'd1);
    drive(we, f3, addr, wdata, rd);
  endtask

  // Cycles from the acceptance edge to the cycle showing resp_valid
  task automatic wait_resp(input int exp_lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int low;
    logic busy_all;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0;
    bus_rdata = 32'h12F4_5678;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_byte_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);

    // SB accepted on the first edge after reset release
    exp_bus.push_back('{1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5});
    exp_resp.push_back('{32'd0, 5'd0, 1'b0, 2'd0});
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd9);
    chk("first_edge_accept", 32'(bus_req), 32'd1);
    wait_resp(3, "lat_sb");

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'hFFFF_FFF4, 5'd7, 1'b0, 2'd0});
    issue(1'b0, 3'b000, 32'h2002, 32'd0, 5'd7);
    wait_resp(3, "lat_lb");

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_00F4, 5'd7, 1'b0, 2'd0});
    issue(1'b0, 3'b100, 32'h2002, 32'd0, 5'd7);
    wait_resp(3, "lat_lbu");

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_0056, 5'd6, 1'b0, 2'd0});
    issue(1'b0, 3'b000, 32'h2001, 32'd0, 5'd6);
    wait_resp(3, "lat_lb1");

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_12F4, 5'd8, 1'b0, 2'd0});
    issue(1'b0, 3'b001, 32'h2002, 32'd0, 5'd8);
    wait_resp(3, "lat_lh");

    // Two wait states before the ack
    ack_lat = 2;
    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_5678, 5'd9, 1'b0, 2'd0});
    issue(1'b0, 3'b101, 32'h2000, 32'd0, 5'd9);
    wait_resp(5, "lat_lhu_wait2");
    chk("burst_wait2", 32'(last_burst), 32'd3);
    ack_lat = 0;

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h12F4_5678, 5'd10, 1'b0, 2'd0});
    issue(1'b0, 3'b010, 32'h2000, 32'd0, 5'd10);
    wait_resp(3, "lat_lw");

    exp_bus.push_back('{1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF});
    exp_resp.push_back('{32'd0, 5'd0, 1'b0, 2'd0});
    issue(1'b1, 3'b001, 32'h2002, 32'h1234_BEEF, 5'd11);
    wait_resp(3, "lat_sh");

    exp_bus.push_back('{1'b1, 32'h2004, 4'b1111, 32'hDEAD_BEEF});
    exp_resp.push_back('{32'd0, 5'd0, 1'b0, 2'd0});
    issue(1'b1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 5'd11);
    wait_resp(3, "lat_sw");

    // Error requests: no bus access, response two cycles after acceptance
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd1});
    issue(1'b0, 3'b010, 32'h3002, 32'd0, 5'd5);
    wait_resp(2, "lat_lw_misalign");
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd1});
    issue(1'b0, 3'b001, 32'h3001, 32'd0, 5'd5);
    wait_resp(2, "lat_lh_misalign");
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd2});
    issue(1'b0, 3'b011, 32'h3001, 32'd0, 5'd5);
    wait_resp(2, "lat_ld_illegal");
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd2});
    issue(1'b1, 3'b100, 32'h3000, 32'h55, 5'd5);
    wait_resp(2, "lat_st_illegal");
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd1});
    issue(1'b1, 3'b010, 32'h3001, 32'h55, 5'd5);
    wait_resp(2, "lat_sw_misalign");

    // Timeout with a late ack arriving after the request drops
    ack_lat = -1;
    stray_ack = 1'b1;
    exp_bus.push_back('{1'b1, 32'h4000, 4'b1111, 32'h1122_3344});
    exp_resp.push_back('{32'd0, 5'd0, 1'b1, 2'd3});
    issue(1'b1, 3'b010, 32'h4000, 32'h1122_3344, 5'd12);
    wait_resp(6, "lat_timeout");
    chk("burst_timeout", 32'(last_burst), 32'd4);
    @(negedge clk);
    stray_ack = 1'b0;
    ack_lat = 0;

    // Back-to-back halfword loads with req_valid held
    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_12F4, 5'd3, 1'b0, 2'd0});
    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h0000_5678, 5'd4, 1'b0, 2'd0});
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h2002; req_wdata = '0; req_rd = 5'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    low = 0;
    busy_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) busy_all = 1'b0;
      if (req_ready) break;
      low++;
    end
    chk("b2b_ready_low", 32'(low), 32'd3);
    req_addr = 32'h2000;
    req_rd = 5'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!busy) busy_all = 1'b0;
    end
    chk("b2b_busy", 32'(busy_all), 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a bus access
    ack_lat = -1;
    exp_bus.push_back('{1'b1, 32'h5000, 4'b1111, 32'hCAFE_F00D});
    issue(1'b1, 3'b010, 32'h5000, 32'hCAFE_F00D, 5'd1);
    repeat (2) @(negedge clk);
    chk("midrst_pre_bus_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ack_lat = 0;
    repeat (8) @(negedge clk);
    chk("midrst_ready_after", 32'(req_ready), 32'd1);

    exp_bus.push_back('{1'b0, 32'h2000, 4'b1111, 32'd0});
    exp_resp.push_back('{32'h12F4_5678, 5'd2, 1'b0, 2'd0});
    issue(1'b0, 3'b010, 32'h2000, 32'd0, 5'd2);
    wait_resp(3, "lat_after_reset");

    repeat (4) @(negedge clk);
    chk("drain_resp", 32'(exp_resp.size()), 32'd0);
    chk("drain_bus", 32'(exp_bus.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
